// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman host-side blocks.
// Letter classification helpers used by the word entry stage.
package hangman_pkg;

    typedef enum logic {
        ENTRY  = 1'b0,
        LOCKED = 1'b1
    } entry_state_t;

    localparam int WORD_LEN_DEF = 5;

    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LZ    = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LA) && (c <= ASCII_LZ);
    endfunction

endpackage

// File: rtl/ascii_letter_norm.sv
// Combinational letter classifier.
// Accepts A-Z unchanged, folds a-z to upper case, rejects the rest.
module ascii_letter_norm
    import hangman_pkg::*;
(
    input  logic [7:0] i_code,
    output logic       o_is_letter,
    output logic [7:0] o_letter
);

    logic w_upper;
    logic w_lower;

    assign w_upper = is_upper(i_code);
    assign w_lower = is_lower(i_code);

    // Classify and fold lower case onto upper case.
    always_comb begin
        o_is_letter = 1'b0;
        o_letter    = 8'h00;
        if (w_upper) begin
            o_is_letter = 1'b1;
            o_letter    = i_code;
        end else if (w_lower) begin
            o_is_letter = 1'b1;
            o_letter    = i_code - CASE_OFFSET;
        end
    end

endmodule

// File: rtl/word_entry.sv
// Secret word capture stage feeding the game-logic FSM.
// Collects letters, supports backspace, hands the word over on confirm.
module word_entry
    import hangman_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  key_valid,
    input  logic [7:0]            key_data,
    input  logic                  key_del,
    input  logic                  key_confirm,
    input  logic                  game_rdy,
    input  logic                  gameEnd,
    output logic [8*WORD_LEN-1:0] setWord,
    output logic                  toggle_state,
    output logic [2:0]            letter_count,
    output logic                  word_locked,
    output logic                  bad_key
);

    localparam int         W     = 8 * WORD_LEN;
    localparam logic [2:0] LEN_C = 3'(WORD_LEN);

    entry_state_t   r_state;
    logic [W-1:0]   r_word;
    logic [2:0]     r_count;
    logic           r_toggle;
    logic           r_locked;
    logic           r_bad;

    logic           w_is_letter;
    logic [7:0]     w_letter;
    logic           w_full;
    logic           w_empty;

    ascii_letter_norm u_norm (
        .i_code      (key_data),
        .o_is_letter (w_is_letter),
        .o_letter    (w_letter)
    );

    assign w_full  = (r_count == LEN_C);
    assign w_empty = (r_count == 3'd0);

    // Entry FSM: shift register, letter counter and pulse outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state  <= ENTRY;
            r_word   <= '0;
            r_count  <= 3'd0;
            r_toggle <= 1'b0;
            r_locked <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_toggle <= 1'b0;
            r_bad    <= 1'b0;
            if (gameEnd) begin
                r_state  <= ENTRY;
                r_word   <= '0;
                r_count  <= 3'd0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ENTRY: begin
                        if (key_valid) begin
                            if (key_confirm) begin
                                if (w_full && game_rdy) begin
                                    r_toggle <= 1'b1;
                                    r_locked <= 1'b1;
                                    r_state  <= LOCKED;
                                end else begin
                                    r_bad <= 1'b1;
                                end
                            end else if (key_del) begin
                                if (!w_empty) begin
                                    r_word  <= r_word >> 8;
                                    r_count <= r_count - 3'd1;
                                end else begin
                                    r_bad <= 1'b1;
                                end
                            end else if (w_is_letter) begin
                                if (!w_full) begin
                                    r_word  <= {r_word[W-9:0], w_letter};
                                    r_count <= r_count + 3'd1;
                                end else begin
                                    r_bad <= 1'b1;
                                end
                            end else begin
                                r_bad <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        r_state <= LOCKED;
                    end
                    default: begin
                        r_state <= ENTRY;
                    end
                endcase
            end
        end
    end

    assign setWord      = r_word;
    assign toggle_state = r_toggle;
    assign letter_count = r_count;
    assign word_locked  = r_locked;
    assign bad_key      = r_bad;

endmodule

// File: tb/tb_word_entry.sv
// Directed bench for word_entry with an expectation queue.
// Each step pushes the expected outputs, clocks, then pops and checks.
module tb_word_entry;

    logic        clk;
    logic        nRst;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_del;
    logic        key_confirm;
    logic        game_rdy;
    logic        gameEnd;
    logic [39:0] setWord;
    logic        toggle_state;
    logic [2:0]  letter_count;
    logic        word_locked;
    logic        bad_key;

    typedef struct packed {
        logic [39:0] word;
        logic [2:0]  cnt;
        logic        tog;
        logic        lock;
        logic        bad;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    word_entry dut (
        .clk          (clk),
        .nRst         (nRst),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_del      (key_del),
        .key_confirm  (key_confirm),
        .game_rdy     (game_rdy),
        .gameEnd      (gameEnd),
        .setWord      (setWord),
        .toggle_state (toggle_state),
        .letter_count (letter_count),
        .word_locked  (word_locked),
        .bad_key      (bad_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [39:0] w, input logic [2:0] c,
                        input logic t, input logic l, input logic b);
        exp_t e;
        e.word = w;
        e.cnt  = c;
        e.tog  = t;
        e.lock = l;
        e.bad  = b;
        q.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed empty-queue expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".word"}, setWord, e.word);
            chk({tag, ".cnt"}, 40'(letter_count), 40'(e.cnt));
            chk({tag, ".tog"}, 40'(toggle_state), 40'(e.tog));
            chk({tag, ".lock"}, 40'(word_locked), 40'(e.lock));
            chk({tag, ".bad"}, 40'(bad_key), 40'(e.bad));
        end
    endtask

    // One clock step: drive, push expected, clock, sample #1 later.
    task automatic step(input string tag, input logic kv,
                        input logic [7:0] kd, input logic kdel,
                        input logic kconf, input logic ge,
                        input logic [39:0] w, input logic [2:0] c,
                        input logic t, input logic l, input logic b);
        key_valid   = kv;
        key_data    = kd;
        key_del     = kdel;
        key_confirm = kconf;
        gameEnd     = ge;
        push(w, c, t, l, b);
        @(posedge clk);
        #1;
        key_valid   = 1'b0;
        key_data    = 8'h00;
        key_del     = 1'b0;
        key_confirm = 1'b0;
        gameEnd     = 1'b0;
        compare(tag);
    endtask

    initial begin
        nRst        = 1'b0;
        key_valid   = 1'b0;
        key_data    = 8'h00;
        key_del     = 1'b0;
        key_confirm = 1'b0;
        game_rdy    = 1'b1;
        gameEnd     = 1'b0;
        #12;
        push(40'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        compare("reset");
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;

        step("h", 1, 8'h68, 0, 0, 0, 40'h48, 1, 0, 0, 0);
        step("e", 1, 8'h65, 0, 0, 0, 40'h4845, 2, 0, 0, 0);
        step("l1", 1, 8'h6C, 0, 0, 0, 40'h48454C, 3, 0, 0, 0);
        step("l2", 1, 8'h6C, 0, 0, 0, 40'h48454C4C, 4, 0, 0, 0);
        step("o", 1, 8'h6F, 0, 0, 0, 40'h48454C4C4F, 5, 0, 0, 0);
        step("conf", 1, 8'h00, 0, 1, 0, 40'h48454C4C4F, 5, 1, 1, 0);
        step("post", 0, 8'h00, 0, 0, 0, 40'h48454C4C4F, 5, 0, 1, 0);
        step("lkQ", 1, 8'h51, 0, 0, 0, 40'h48454C4C4F, 5, 0, 1, 0);
        step("lkdel", 1, 8'h00, 1, 0, 0, 40'h48454C4C4F, 5, 0, 1, 0);
        step("lkconf", 1, 8'h00, 0, 1, 0, 40'h48454C4C4F, 5, 0, 1, 0);
        step("geQ", 1, 8'h51, 0, 0, 1, 40'h0, 0, 0, 0, 0);

        step("A", 1, 8'h41, 0, 0, 0, 40'h41, 1, 0, 0, 0);
        step("B", 1, 8'h42, 0, 0, 0, 40'h4142, 2, 0, 0, 0);
        step("del", 1, 8'h00, 1, 0, 0, 40'h41, 1, 0, 0, 0);
        step("C", 1, 8'h43, 0, 0, 0, 40'h4143, 2, 0, 0, 0);
        step("del2", 1, 8'h41, 1, 0, 0, 40'h41, 1, 0, 0, 0);
        step("del3", 1, 8'h00, 1, 0, 0, 40'h0, 0, 0, 0, 0);
        step("delE", 1, 8'h00, 1, 0, 0, 40'h0, 0, 0, 0, 1);
        step("idle", 0, 8'h00, 0, 0, 0, 40'h0, 0, 0, 0, 0);

        step("a", 1, 8'h61, 0, 0, 0, 40'h41, 1, 0, 0, 0);
        step("b", 1, 8'h62, 0, 0, 0, 40'h4142, 2, 0, 0, 0);
        step("c", 1, 8'h63, 0, 0, 0, 40'h414243, 3, 0, 0, 0);
        step("d", 1, 8'h64, 0, 0, 0, 40'h41424344, 4, 0, 0, 0);
        step("e5", 1, 8'h65, 0, 0, 0, 40'h4142434445, 5, 0, 0, 0);
        step("Zfull", 1, 8'h5A, 0, 0, 0, 40'h4142434445, 5, 0, 0, 1);
        game_rdy = 1'b0;
        step("confNR", 1, 8'h00, 0, 1, 0, 40'h4142434445, 5, 0, 0, 1);
        step("stillE", 1, 8'h00, 1, 0, 0, 40'h41424344, 4, 0, 0, 0);
        step("E", 1, 8'h45, 0, 0, 0, 40'h4142434445, 5, 0, 0, 0);
        game_rdy = 1'b1;
        step("confR", 1, 8'h00, 0, 1, 0, 40'h4142434445, 5, 1, 1, 0);
        step("post2", 0, 8'h00, 0, 0, 0, 40'h4142434445, 5, 0, 1, 0);
        step("ge2", 0, 8'h00, 0, 0, 1, 40'h0, 0, 0, 0, 0);

        step("X", 1, 8'h58, 0, 0, 0, 40'h58, 1, 0, 0, 0);
        step("Y", 1, 8'h59, 0, 0, 0, 40'h5859, 2, 0, 0, 0);
        step("k3", 1, 8'h33, 0, 0, 0, 40'h5859, 2, 0, 0, 1);
        step("k00", 1, 8'h00, 0, 0, 0, 40'h5859, 2, 0, 0, 1);
        step("k40", 1, 8'h40, 0, 0, 0, 40'h5859, 2, 0, 0, 1);
        step("k5B", 1, 8'h5B, 0, 0, 0, 40'h5859, 2, 0, 0, 1);
        step("k60", 1, 8'h60, 0, 0, 0, 40'h5859, 2, 0, 0, 1);
        step("k7B", 1, 8'h7B, 0, 0, 0, 40'h5859, 2, 0, 0, 1);
        step("z", 1, 8'h7A, 0, 0, 0, 40'h58595A, 3, 0, 0, 0);
        step("W", 1, 8'h57, 0, 0, 0, 40'h58595A57, 4, 0, 0, 0);
        step("conf4", 1, 8'h00, 0, 1, 0, 40'h58595A57, 4, 0, 0, 1);
        step("confdel", 1, 8'h00, 1, 1, 0, 40'h58595A57, 4, 0, 0, 1);
        step("dellet", 1, 8'h41, 1, 0, 0, 40'h58595A, 3, 0, 0, 0);
        step("noval", 0, 8'h41, 0, 0, 0, 40'h58595A, 3, 0, 0, 0);

        @(negedge clk);
        #2;
        nRst = 1'b0;
        #1;
        push(40'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        compare("rstmid");
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;

        step("Q", 1, 8'h51, 0, 0, 0, 40'h51, 1, 0, 0, 0);
        step("u", 1, 8'h75, 0, 0, 0, 40'h5155, 2, 0, 0, 0);
        step("i", 1, 8'h69, 0, 0, 0, 40'h515549, 3, 0, 0, 0);
        step("c2", 1, 8'h63, 0, 0, 0, 40'h51554943, 4, 0, 0, 0);
        step("k", 1, 8'h6B, 0, 0, 0, 40'h515549434B, 5, 0, 0, 0);
        step("confQ", 1, 8'h00, 0, 1, 0, 40'h515549434B, 5, 1, 1, 0);
        step("heldQ", 0, 8'h00, 0, 0, 0, 40'h515549434B, 5, 0, 1, 0);

        @(negedge clk);
        #2;
        nRst = 1'b0;
        #1;
        push(40'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        compare("rstlock");
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;
        step("after", 1, 8'h4A, 0, 0, 0, 40'h4A, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
